// File: rtl/alu_input_sequencer.sv
// Board-level sequencer: three buttons latch shared switches into operand A, operand B and the opcode,
// then the ALU result is captured one cycle later. Optional macro DEBOUNCE_EN adds per-button debounce.
module alu_input_sequencer #(
  parameter int N_BITS          = 8,
  parameter int N_OP            = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] sw,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic              btn_op,
  input  logic [N_BITS-1:0] alu_result,
  output logic [N_BITS-1:0] alu_a,
  output logic [N_BITS-1:0] alu_b,
  output logic [N_OP-1:0]   alu_op,
  output logic [N_BITS-1:0] result,
  output logic              result_valid,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Button vectors are ordered {op, b, a}.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0] level;
  logic [2:0] prev_q, prev_d, pulse_q, pulse_d;

  assign btn_raw = {btn_op, btn_b, btn_a};

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            deb_q, deb_d;

  // Count consecutive high samples; saturate at the threshold so a held button stays high.
  always_comb begin
    cnt_d = '0;
    deb_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i]) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
      end
      deb_d[i] = sync2_q[i] && (cnt_d[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = level;
    pulse_d = level & ~prev_q;
  end

  // NOTE: non-blocking assignments keep every stage of the synchronizer chain a distinct flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  state_t            state_q;
  logic [N_BITS-1:0] alu_a_q, alu_b_q, result_q;
  logic [N_OP-1:0]   alu_op_q;
  logic              valid_q;

  // Priority a > b > op falls out of the if/else chains; lower pulses are simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_A;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (pulse_q[0]) begin
            alu_a_q <= sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (pulse_q[0]) begin
            alu_a_q <= sw;
          end else if (pulse_q[1]) begin
            alu_b_q <= sw;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (pulse_q[0]) begin
            alu_a_q <= sw;
          end else if (pulse_q[1]) begin
            alu_b_q <= sw;
          end else if (pulse_q[2]) begin
            alu_op_q <= sw[N_OP-1:0];
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= alu_result;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (pulse_q[0]) begin
            alu_a_q <= sw;
            valid_q <= 1'b0;
            state_q <= S_B;
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with an OR ALU; the debounce scenario runs only when
// DEBOUNCE_EN is defined (the DUT is then built with a 4-cycle threshold).
module tb_alu_input_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, result;
  logic [5:0] alu_op;
  logic       result_valid;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  alu_input_sequencer #(
    .N_BITS(8),
    .N_OP(6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .btn_a(btn_a),
    .btn_b(btn_b),
    .btn_op(btn_op),
    .alu_result(alu_result),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .result(result),
    .result_valid(result_valid),
    .state(state)
  );

  // Lab ALU stand-in: 8-bit OR.
  assign alu_result = alu_a | alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: drive switches and buttons {op,b,a}, hold for `hold` edges, release,
  // then wait `after` more edges and return on a negedge.
  task automatic press(input logic [2:0] btns, input logic [7:0] v, input int hold, input int after);
    sw = v;
    {btn_op, btn_b, btn_a} = btns;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    {btn_op, btn_b, btn_a} = 3'b000;
    repeat (after) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 8'h00;
    {btn_op, btn_b, btn_a} = 3'b000;
    #1;
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_state", state, 3'd0);
    tick(2);
    reset = 1'b0;
    tick(1);

`ifndef DEBOUNCE_EN
    // Out-of-order buttons from S_A are ignored.
    press(3'b100, 8'h25, 1, 4);
    press(3'b010, 8'h11, 1, 4);
    check("t2_alu_b", alu_b, 8'h00);
    check("t2_alu_op", alu_op, 6'h00);
    check("t2_state", state, 3'd0);

    // Basic A/B/op sequence with exact load timing.
    press(3'b001, 8'h0F, 1, 2);
    check("t1_a_not_yet", alu_a, 8'h00);
    tick(1);
    check("t1_alu_a", alu_a, 8'h0F);
    check("t1_state_b", state, 3'd1);
    press(3'b010, 8'hF0, 1, 4);
    check("t1_alu_b", alu_b, 8'hF0);
    check("t1_state_op", state, 3'd2);
    press(3'b100, 8'h25, 1, 2);
    check("t1_op_not_yet", alu_op, 6'h00);
    tick(1);
    check("t1_alu_op", alu_op, 6'h25);
    check("t1_state_exec", state, 3'd3);
    check("t1_valid_early", result_valid, 1'b0);
    tick(1);
    check("t1_result", result, 8'hFF);
    check("t1_valid", result_valid, 1'b1);
    check("t1_state_done", state, 3'd4);

    // New operation from S_DONE, correction of A in S_OP, opcode upper bits dropped.
    press(3'b001, 8'h0F, 1, 4);
    check("t3_state_b", state, 3'd1);
    check("t3_valid_clr", result_valid, 1'b0);
    press(3'b010, 8'hF0, 1, 4);
    press(3'b001, 8'h33, 1, 4);
    check("t3_alu_a_fix", alu_a, 8'h33);
    check("t3_state_op", state, 3'd2);
    press(3'b100, 8'hE5, 1, 5);
    check("t3_alu_op_trunc", alu_op, 6'h25);
    check("t3_result", result, 8'hF3);
    check("t3_valid", result_valid, 1'b1);

    // Simultaneous a+b in S_B, then a long hold on b loads once.
    press(3'b001, 8'h01, 1, 4);
    press(3'b011, 8'h55, 1, 4);
    check("t4_alu_a", alu_a, 8'h55);
    check("t4_alu_b_kept", alu_b, 8'hF0);
    check("t4_state_b", state, 3'd1);
    sw    = 8'h66;
    btn_b = 1'b1;
    tick(6);
    sw = 8'h77;
    tick(14);
    btn_b = 1'b0;
    tick(4);
    check("t4_hold_once", alu_b, 8'h66);
    check("t4_state_op", state, 3'd2);

    // Asynchronous reset in S_OP.
    press(3'b100, 8'h00, 1, 5);
    check("t5_result", result, 8'h77);
    press(3'b001, 8'h0F, 1, 4);
    press(3'b010, 8'hF0, 1, 4);
    check("t5_state_op", state, 3'd2);
    reset = 1'b1;
    #1;
    check("t5_alu_a", alu_a, 8'h00);
    check("t5_alu_b", alu_b, 8'h00);
    check("t5_result_rst", result, 8'h00);
    check("t5_valid", result_valid, 1'b0);
    check("t5_state", state, 3'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    press(3'b010, 8'h12, 1, 4);
    check("t5_b_ignored", alu_b, 8'h00);
    check("t5_state_after", state, 3'd0);
`else
    // Short glitch shorter than the 4-cycle threshold never loads.
    do_reset();
    press(3'b001, 8'hAA, 3, 10);
    check("t6_glitch_alu_a", alu_a, 8'h00);
    check("t6_glitch_state", state, 3'd0);
    sw    = 8'hAA;
    btn_a = 1'b1;
    tick(9);
    sw = 8'hBB;
    tick(6);
    btn_a = 1'b0;
    tick(10);
    check("t6_alu_a", alu_a, 8'hAA);
    check("t6_state", state, 3'd1);
    // Sequence still completes through the debounced path.
    press(3'b010, 8'h0C, 8, 10);
    press(3'b100, 8'h01, 8, 12);
    check("t6_alu_b", alu_b, 8'h0C);
    check("t6_result", result, 8'hAE);
    check("t6_state_done", state, 3'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
Board-level controller that sequences the lab ALU (bitwise/arithmetic units such as the 8-bit OR) from one shared bank of switches.
- Three push-buttons latch the switches into operand A, operand B and the opcode, in that order.
- The block drives the ALU operand and opcode inputs, captures the ALU result one cycle later and holds it for the LEDs.
- Sits between board I/O and the combinational ALU in the TP1 top level.

Parameters:
N_BITS, 8, operand/result width
N_OP, 6, opcode width (taken from sw[N_OP-1:0])
DEBOUNCE_CYCLES, 16, stable-high cycles required per button (used only with DEBOUNCE_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sw  input  N_BITS  shared data switches
btn_a  input  1  load operand A (raw, asynchronous to clk)
btn_b  input  1  load operand B (raw)
btn_op  input  1  load opcode and execute (raw)
alu_result  input  N_BITS  combinational result from ALU
alu_a  output  N_BITS  operand A to ALU (registered)
alu_b  output  N_BITS  operand B to ALU (registered)
alu_op  output  N_OP  opcode to ALU (registered)
result  output  N_BITS  captured result (registered)
result_valid  output  1  result holds the current operation's output
state  output  3  FSM state for debug LEDs

Behaviour:
- One clock, asynchronous active-high reset.
- Reset, including mid-operation:
  - alu_a, alu_b, alu_op, result all 0; result_valid 0; state S_A.
  - Synchronizer, edge and debounce registers cleared.
  - Any partial operation is discarded.
- Button path:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector that produces a 1-cycle pulse.
  - A held button yields exactly one pulse; a new pulse requires release (sync low for 1+ cycles) and a new press.
  - Without debounce: button high before edge k -> pulse during cycle after edge k+2 -> target register updates at edge k+3.
- FSM states and encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4. Unused codes go to S_A.
  - S_A: pulse_a -> alu_a<=sw, go S_B. pulse_b and pulse_op ignored.
  - S_B: pulse_a -> alu_a<=sw, stay (correction). Else pulse_b -> alu_b<=sw, go S_OP. pulse_op ignored.
  - S_OP: pulse_a -> reload alu_a, stay. Else pulse_b -> reload alu_b, stay. Else pulse_op -> alu_op<=sw[N_OP-1:0], go S_EXEC.
  - S_EXEC: unconditional, exactly one cycle: result<=alu_result, result_valid<=1, go S_DONE. Pulses in this cycle are dropped.
  - S_DONE: result and operands held. pulse_a -> alu_a<=sw, result_valid<=0, go S_B (new operation). pulse_b and pulse_op ignored.
- Simultaneous pulses: priority a > b > op; at most one register loads per cycle; lower-priority pulses are dropped, not queued.
- Latency: opcode load edge -> result valid on the next edge (1 cycle). ALU must settle within one clock.
- Opcode values are passed through unchecked; invalid-opcode handling belongs to the ALU.
- Widths: sw is copied without extension. alu_op takes the low N_OP bits; upper sw bits are ignored for the opcode.

Optional Feature:
DEBOUNCE_EN
- Defined: each synchronized button feeds a per-button counter.
  - Counter counts consecutive high cycles and resets to 0 on any low sample.
  - The debounced level goes high when the count reaches DEBOUNCE_CYCLES and goes low on the first low sample.
  - The edge detector operates on the debounced level, adding DEBOUNCE_CYCLES cycles of press latency.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Undefined: no counters; the edge detector works directly on the synchronized level.

Test Plan:
1. Reset; ALU model = OR. sw=0x0F + btn_a, sw=0xF0 + btn_b, sw=0x25 + btn_op -> alu_a=0x0F, alu_b=0xF0, alu_op=0x25; result=0xFF and result_valid=1 one edge after alu_op loads; state=4.
2. From reset, btn_op with sw=0x25, then btn_b with sw=0x11 -> no register changes, state stays 0.
3. In S_OP (A=0x0F, B=0xF0), btn_a with sw=0x33 -> alu_a=0x33, state stays 2; then btn_op -> result=0xF3.
4. In S_B, btn_a and btn_b pressed on the same cycle with sw=0x55 -> only alu_a=0x55, state stays 1; btn_b held for 20 cycles loads once.
5. Assert reset while in S_OP with A=0x0F, B=0xF0 -> all outputs 0, state 0 immediately (asynchronous, no clock edge needed); after release, btn_b ignored.
6. DEBOUNCE_EN, DEBOUNCE_CYCLES=4: btn_a high 3 cycles then low -> no load. btn_a high 10 cycles with sw=0xAA -> alu_a=0xAA exactly once.
